// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request and response handshake.
// Each access waits a fixed LATENCY, then holds its response until the initiator accepts it.

module data_mem_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  // Storage has no reset, so its contents survive a reset pulse.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int NUM_LANES = 4;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [NUM_LANES-1:0] wstrb;
  } req_t;

  state_t state, state_n;
  logic [3:0]  cnt;
  req_t        req_q, req_in, cur;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, hshake, enter_resp, fault;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  wbytes, rbytes;
  logic [AW-1:0] idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign hshake    = (state == RESP) & resp_ready;
  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // With LATENCY=0 the memory is accessed on the acceptance edge itself,
  // so the live request is used until it has been captured.
  assign cur   = (state == IDLE) ? req_in : req_q;
  assign idx   = cur.addr[AW+1:2];
  assign fault = (|cur.addr[1:0]) || ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt <= 4'd1) state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_n == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        req_q <= req_in;
        cnt   <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= fault;
        rdata_q <= (fault || cur.we) ? 32'h0 : rbytes;
      end else if (hshake) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign wbytes = cur.wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = enter_resp & cur.we & ~fault & cur.wstrb[i];
    data_mem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (idx),
      .wdata (wbytes[i]),
      .rdata (rbytes[i])
    );
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random traffic against a word-array model.
module tb_data_mem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;

  logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_err0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0;
  logic [3:0]  req_wstrb0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mm  [DEPTH];
  logic [31:0] mm0 [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
    while (!req_ready && n < 40) begin step(); n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    step();
    // captured fields must not follow the inputs after acceptance
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
  endtask

  task automatic get_resp(input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int lat = 1;
    while (!resp_valid && lat < 40) begin step(); lat++; end
    chk("latency", 32'(lat), 32'(LAT + 1));
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", 32'(resp_err), 32'(exp_err));
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      step();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", 32'(resp_err), 32'(exp_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", 32'(resp_err), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold);
    logic        err;
    logic [31:0] exp;
    err = (a % 4 != 0) || (a / 4 >= DEPTH);
    exp = (err || we) ? 32'h0 : mm[a[9:2]];
    issue(we, a, wd, ws);
    get_resp(exp, err, hold);
    if (!err && we)
      for (int b = 0; b < 4; b++)
        if (ws[b]) mm[a[9:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    logic [31:0] a, d;
    logic        we;
    int          n, sel;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_wstrb0 = 0; resp_ready0 = 1;

    // reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ready0", 32'(req_ready0), 32'd1);

    // zero latency, back-to-back with resp_ready tied high: one response every 2 cycles
    req_valid0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_ready_idle", 32'(req_ready0), 32'd1);
      chk("b2b_valid_idle", 32'(resp_valid0), 32'd0);
      req_we0 = (k < 4); req_addr0 = 32'(4 * (k % 4));
      req_wdata0 = $urandom; req_wstrb0 = 4'hF;
      d = (k < 4) ? 32'h0 : mm0[k - 4];
      if (k < 4) mm0[k] = req_wdata0;
      step();
      chk("b2b_valid", 32'(resp_valid0), 32'd1);
      chk("b2b_ready_resp", 32'(req_ready0), 32'd0);
      chk("b2b_rdata", resp_rdata0, d);
      chk("b2b_err", 32'(resp_err0), 32'd0);
      req_we0 = 1'b1; req_addr0 = $urandom; req_wdata0 = $urandom;
      step();
    end
    req_valid0 = 1'b0;

    // give every word a known value
    for (int w = 0; w < DEPTH; w++) access(1'b1, 32'(w * 4), $urandom, 4'hF, 0);

    // full store then load, partial store, faults
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 0);
    access(1'b1, 32'h10, 32'h11223344, 4'h3, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("partial_model", mm[4], 32'hDEAD3344);
    access(1'b0, 32'h12, 32'h0, 4'hF, 0);
    access(1'b0, 32'h400, 32'h0, 4'hF, 0);
    access(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0);
    access(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    access(1'b1, 32'h10, 32'h55555555, 4'h0, 0);
    access(1'b0, 32'h10, 32'h0, 4'h0, 0);
    access(1'b0, 32'h3FC, 32'h0, 4'h0, 0);

    // stalled response with a second request pending
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_wdata = 0; req_wstrb = 0;
    get_resp(mm[4], 1'b0, 5);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    get_resp(mm[5], 1'b0, 0);

    // reset during WAIT abandons the store
    issue(1'b1, 32'h20, ~mm[8], 4'hF);
    rst = 1'b0;
    #1;
    chk("rstw_valid", 32'(resp_valid), 32'd0);
    chk("rstw_rdata", resp_rdata, 32'd0);
    chk("rstw_err", 32'(resp_err), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("rstw_ready", 32'(req_ready), 32'd1);
    access(1'b0, 32'h20, 32'h0, 4'h0, 0);

    // reset during RESP drops the response, store already committed
    d = ~mm[9];
    issue(1'b1, 32'h24, d, 4'hF);
    n = 0;
    while (!resp_valid && n < 40) begin step(); n++; end
    chk("rstr_valid_before", 32'(resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstr_valid", 32'(resp_valid), 32'd0);
    chk("rstr_err", 32'(resp_err), 32'd0);
    mm[9] = d;
    step();
    rst = 1'b1;
    step();
    chk("rstr_ready", 32'(req_ready), 32'd1);
    access(1'b0, 32'h24, 32'h0, 4'h0, 0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      we  = 1'($urandom);
      if (sel == 0)      a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h400 | ($urandom & 32'hFFFF_FFFC);
      else               a = 32'($urandom_range(0, 255)) << 2;
      access(we, a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
